// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the round-robin data-memory arbiter: request codes,
// FSM state encoding and the default widths used by the core array.
package mem_arbiter_pkg;

    localparam int DEF_NUM_CORES = 4;
    localparam int DEF_REG_W     = 8;
    localparam int DEF_ADDR_W    = 12;
    localparam int DEF_MEM_LAT   = 2;

    localparam logic [1:0] MEM_EN_IDLE = 2'b00;
    localparam logic [1:0] MEM_EN_LD   = 2'b01;
    localparam logic [1:0] MEM_EN_ST   = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } arb_state_e;

    // 2'b11 is an illegal code and must never count as a request.
    function automatic logic is_req(input logic [1:0] en);
        logic r;
        case (en)
            MEM_EN_LD, MEM_EN_ST: r = 1'b1;
            MEM_EN_IDLE:          r = 1'b0;
            default:              r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the core array, the arbiter and the shared memory bank.
// The master modport is the arbiter's view; slave is the cores/memory side.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_CORES = DEF_NUM_CORES,
    parameter int REG_W     = DEF_REG_W,
    parameter int ADDR_W    = DEF_ADDR_W
);

    logic [2*NUM_CORES-1:0]      core_en;
    logic [NUM_CORES*ADDR_W-1:0] core_addr;
    logic [NUM_CORES*REG_W-1:0]  core_wdata;
    logic [REG_W-1:0]            core_rdata;
    logic [NUM_CORES-1:0]        core_ready;

    logic                        mem_req;
    logic                        mem_we;
    logic [ADDR_W-1:0]           mem_addr;
    logic [REG_W-1:0]            mem_wdata;
    logic [REG_W-1:0]            mem_rdata;

    modport master (
        input  core_en, core_addr, core_wdata, mem_rdata,
        output core_rdata, core_ready, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output core_en, core_addr, core_wdata, mem_rdata,
        input  core_rdata, core_ready, mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr,
// wrapping modulo NUM_CORES.
module mem_arbiter_rr_picker
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_CORES = DEF_NUM_CORES
) (
    input  logic [NUM_CORES-1:0]         valid_i,
    input  logic [$clog2(NUM_CORES)-1:0] rr_ptr_i,
    output logic                         any_valid_o,
    output logic [$clog2(NUM_CORES)-1:0] winner_o
);

    localparam int ID_W = $clog2(NUM_CORES);

    int idx;

    // Walk offsets from farthest to nearest so the closest valid one wins.
    always_comb begin
        any_valid_o = 1'b0;
        winner_o    = '0;
        idx         = 0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_i) + k) % NUM_CORES;
            if (valid_i[idx]) begin
                any_valid_o = 1'b1;
                winner_o    = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory among NUM_CORES cores.
// Optional macro MEM_ARB_ST_FASTPATH_EN: stores complete in the REQ cycle.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_CORES = DEF_NUM_CORES,
    parameter int REG_W     = DEF_REG_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int MEM_LAT   = DEF_MEM_LAT
) (
    input  logic                         clk,
    input  logic                         reset,
    mem_arbiter_if.master                bus,
    output logic                         busy_o,
    output logic [$clog2(NUM_CORES)-1:0] grant_id_o
);

    localparam int ID_W  = $clog2(NUM_CORES);
    localparam int CNT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((MEM_LAT > 2) ? MEM_LAT - 2 : 0);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_CORES - 1);

    arb_state_e           state_q;
    logic [ID_W-1:0]      rr_ptr_q;
    logic [ID_W-1:0]      grant_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [REG_W-1:0]     wdata_q;
    logic                 we_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 mem_req_q;
    logic [NUM_CORES-1:0] core_ready_q;
    logic [REG_W-1:0]     rdata_q;

    logic [NUM_CORES-1:0] valid;
    logic                 any_valid;
    logic [ID_W-1:0]      winner;
    logic [ADDR_W-1:0]    addr_d;
    logic [REG_W-1:0]     wdata_d;
    logic                 we_d;
    logic [NUM_CORES-1:0] grant_onehot;

    always_comb begin
        valid = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            valid[i] = is_req(bus.core_en[2*i +: 2]);
        end
    end

    mem_arbiter_rr_picker #(
        .NUM_CORES (NUM_CORES)
    ) u_picker (
        .valid_i     (valid),
        .rr_ptr_i    (rr_ptr_q),
        .any_valid_o (any_valid),
        .winner_o    (winner)
    );

    assign addr_d       = bus.core_addr[int'(winner)*ADDR_W +: ADDR_W];
    assign wdata_d      = bus.core_wdata[int'(winner)*REG_W +: REG_W];
    assign we_d         = (bus.core_en[2*int'(winner) +: 2] == MEM_EN_ST);
    assign grant_onehot = NUM_CORES'(1) << grant_q;

`ifdef MEM_ARB_ST_FASTPATH_EN
    logic [NUM_CORES-1:0] win_onehot;
    assign win_onehot = NUM_CORES'(1) << winner;
`endif

    // Ready is registered on the edge entering the completion cycle, so it is
    // high for exactly one cycle; RESP always returns to IDLE without arbitrating.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            cnt_q        <= '0;
            mem_req_q    <= 1'b0;
            core_ready_q <= '0;
            rdata_q      <= '0;
        end else begin
            mem_req_q    <= 1'b0;
            core_ready_q <= '0;
            case (state_q)
                IDLE: begin
                    if (any_valid) begin
                        grant_q   <= winner;
                        addr_q    <= addr_d;
                        wdata_q   <= wdata_d;
                        we_q      <= we_d;
                        mem_req_q <= 1'b1;
                        state_q   <= REQ;
`ifdef MEM_ARB_ST_FASTPATH_EN
                        if (we_d) begin
                            core_ready_q <= win_onehot;
                        end
`endif
                    end
                end
                REQ: begin
                    rr_ptr_q <= (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;
`ifdef MEM_ARB_ST_FASTPATH_EN
                    if (we_q) begin
                        state_q <= IDLE;
                    end else
`endif
                    if (MEM_LAT == 1) begin
                        state_q      <= RESP;
                        core_ready_q <= grant_onehot;
                    end else begin
                        state_q <= WAIT;
                        cnt_q   <= CNT_INIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q      <= RESP;
                        core_ready_q <= grant_onehot;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    if (!we_q) begin
                        rdata_q <= bus.mem_rdata;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Load data is only valid in the RESP cycle, so it passes straight through
    // there and is held from the register afterwards.
    assign bus.core_rdata = (state_q == RESP && !we_q) ? bus.mem_rdata : rdata_q;
    assign bus.core_ready = core_ready_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = we_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign busy_o         = (state_q != IDLE);
    assign grant_id_o     = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: a MEM_LAT=2 instance with a
// behavioural memory, plus a MEM_LAT=1 instance for the short-latency corner.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int NC = 4;
    localparam int RW = 8;
    localparam int AW = 12;
`ifdef MEM_ARB_ST_FASTPATH_EN
    localparam int SLAT = 1;
`else
    localparam int SLAT = 3;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if #(.NUM_CORES(NC), .REG_W(RW), .ADDR_W(AW)) bif ();
    mem_arbiter_if #(.NUM_CORES(NC), .REG_W(RW), .ADDR_W(AW)) bif1 ();

    logic       busy, busy1;
    logic [1:0] gid, gid1;

    mem_arbiter #(.NUM_CORES(NC), .REG_W(RW), .ADDR_W(AW), .MEM_LAT(2)) dut (
        .clk(clk), .reset(reset), .bus(bif.master), .busy_o(busy), .grant_id_o(gid)
    );

    mem_arbiter #(.NUM_CORES(NC), .REG_W(RW), .ADDR_W(AW), .MEM_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bif1.master), .busy_o(busy1), .grant_id_o(gid1)
    );

    int errors = 0;
    int checks = 0;

    logic [RW-1:0] mem0 [0:4095];
    logic [RW-1:0] mem1 [0:4095];
    int            pend0 = 0;
    logic [AW-1:0] paddr0;

    // Read data becomes valid MEM_LAT-1 edges after the sampling edge; garbage before.
    always @(posedge clk) begin
        if (bif.mem_req) begin
            if (bif.mem_we) mem0[bif.mem_addr] <= bif.mem_wdata;
            else begin
                bif.mem_rdata <= 8'hEE;
                paddr0        <= bif.mem_addr;
                pend0         <= 1;
            end
        end else if (pend0 > 0) begin
            pend0 <= pend0 - 1;
            if (pend0 == 1) bif.mem_rdata <= mem0[paddr0];
        end
    end

    always @(posedge clk) begin
        if (bif1.mem_req) begin
            if (bif1.mem_we) mem1[bif1.mem_addr] <= bif1.mem_wdata;
            else bif1.mem_rdata <= mem1[bif1.mem_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input int i, input logic [1:0] en, input logic [AW-1:0] a,
                            input logic [RW-1:0] d);
        bif.core_en[2*i +: 2]     = en;
        bif.core_addr[i*AW +: AW] = a;
        bif.core_wdata[i*RW +: RW] = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bif.core_en = '0; bif.core_addr = '0; bif.core_wdata = '0;
        bif1.core_en = '0; bif1.core_addr = '0; bif1.core_wdata = '0;
        reset = 1'b1;
        set_core(0, MEM_EN_LD, 12'h010, 8'h00);
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (gid !== 2'd0) begin errors++; $display("[TB] FAIL reset_grant_id: got %0d want 0", gid); end
        checks++; if (bif.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_req: got %0b want 0", bif.mem_req); end
        checks++; if (bif.mem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_we: got %0b want 0", bif.mem_we); end
        checks++; if (bif.mem_addr !== 12'h000) begin errors++; $display("[TB] FAIL reset_mem_addr: got %h want 000", bif.mem_addr); end
        checks++; if (bif.mem_wdata !== 8'h00) begin errors++; $display("[TB] FAIL reset_mem_wdata: got %h want 00", bif.mem_wdata); end
        checks++; if (bif.core_ready !== 4'b0000) begin errors++; $display("[TB] FAIL reset_core_ready: got %b want 0000", bif.core_ready); end
        checks++; if (bif.core_rdata !== 8'h00) begin errors++; $display("[TB] FAIL reset_core_rdata: got %h want 00", bif.core_rdata); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy_lat1: got %0b want 0", busy1); end
        set_core(0, MEM_EN_IDLE, 12'h000, 8'h00);
        reset = 1'b0;
    endtask

    task automatic test_single_load();
        do_reset();
        set_core(1, MEM_EN_LD, 12'h105, 8'h00);
        tick();
        checks++; if (bif.mem_req !== 1'b1) begin errors++; $display("[TB] FAIL single_mem_req: got %0b want 1", bif.mem_req); end
        checks++; if (bif.mem_addr !== 12'h105) begin errors++; $display("[TB] FAIL single_mem_addr: got %h want 105", bif.mem_addr); end
        checks++; if (bif.mem_we !== 1'b0) begin errors++; $display("[TB] FAIL single_mem_we: got %0b want 0", bif.mem_we); end
        checks++; if (gid !== 2'd1) begin errors++; $display("[TB] FAIL single_grant_id: got %0d want 1", gid); end
        checks++; if (bif.core_ready !== 4'b0000) begin errors++; $display("[TB] FAIL single_ready_c1: got %b want 0000", bif.core_ready); end
        tick();
        checks++; if (bif.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL single_req_one_cycle: got %0b want 0", bif.mem_req); end
        checks++; if (bif.core_ready !== 4'b0000) begin errors++; $display("[TB] FAIL single_ready_c2: got %b want 0000", bif.core_ready); end
        tick();
        checks++; if (bif.core_ready !== 4'b0010) begin errors++; $display("[TB] FAIL single_ready_c3: got %b want 0010", bif.core_ready); end
        checks++; if (bif.core_rdata !== 8'hA7) begin errors++; $display("[TB] FAIL single_rdata: got %h want a7", bif.core_rdata); end
        set_core(1, MEM_EN_IDLE, 12'h000, 8'h00);
        tick();
        checks++; if (bif.core_ready !== 4'b0000) begin errors++; $display("[TB] FAIL single_ready_c4: got %b want 0000", bif.core_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_c4: got %0b want 0", busy); end
        checks++; if (bif.core_rdata !== 8'hA7) begin errors++; $display("[TB] FAIL single_rdata_hold: got %h want a7", bif.core_rdata); end
    endtask

    task automatic test_contention();
        int            expOrder [4] = '{0, 2, 3, 0};
        logic [RW-1:0] expData  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        int            served = 0;
        int            id;
        bit            raise0 = 1'b0;
        do_reset();
        set_core(0, MEM_EN_LD, 12'h010, 8'h00);
        set_core(2, MEM_EN_LD, 12'h220, 8'h00);
        set_core(3, MEM_EN_LD, 12'h330, 8'h00);
        for (int cyc = 0; cyc < 60 && served < 4; cyc++) begin
            tick();
            if (raise0 && busy && gid == 2'd2) begin
                set_core(0, MEM_EN_LD, 12'h011, 8'h00);
                raise0 = 1'b0;
            end
            if (bif.core_ready != '0) begin
                id = -1;
                for (int k = 0; k < NC; k++) if (bif.core_ready == (NC'(1) << k)) id = k;
                checks++; if (id != expOrder[served]) begin errors++; $display("[TB] FAIL contention_order%0d: ready=%b want core %0d", served, bif.core_ready, expOrder[served]); end
                checks++; if (bif.core_rdata !== expData[served]) begin errors++; $display("[TB] FAIL contention_rdata%0d: got %h want %h", served, bif.core_rdata, expData[served]); end
                if (id >= 0) set_core(id, MEM_EN_IDLE, 12'h000, 8'h00);
                if (served == 0) raise0 = 1'b1;
                served++;
            end
        end
        checks++; if (served != 4) begin errors++; $display("[TB] FAIL contention_timeout: served %0d want 4", served); end
        bif.core_en = '0;
    endtask

    task automatic test_store_load();
        int            lat = 0;
        logic [NC-1:0] rdy = '0;
        logic [RW-1:0] rd  = '0;
        do_reset();
        set_core(3, MEM_EN_ST, 12'h3FF, 8'h5C);
        tick();
        checks++; if (bif.mem_req !== 1'b1) begin errors++; $display("[TB] FAIL store_mem_req: got %0b want 1", bif.mem_req); end
        checks++; if (bif.mem_we !== 1'b1) begin errors++; $display("[TB] FAIL store_mem_we: got %0b want 1", bif.mem_we); end
        checks++; if (bif.mem_addr !== 12'h3FF) begin errors++; $display("[TB] FAIL store_mem_addr: got %h want 3ff", bif.mem_addr); end
        checks++; if (bif.mem_wdata !== 8'h5C) begin errors++; $display("[TB] FAIL store_mem_wdata: got %h want 5c", bif.mem_wdata); end
        for (int c = 1; c <= SLAT; c++) begin
            if (c > 1) tick();
            checks++;
            if (bif.core_ready !== ((c == SLAT) ? 4'b1000 : 4'b0000)) begin
                errors++;
                $display("[TB] FAIL store_ready_c%0d: got %b want %b", c, bif.core_ready, (c == SLAT) ? 4'b1000 : 4'b0000);
            end
        end
        checks++; if (bif.core_rdata !== 8'h00) begin errors++; $display("[TB] FAIL store_rdata_unchanged: got %h want 00", bif.core_rdata); end
        set_core(3, MEM_EN_IDLE, 12'h000, 8'h00);
        tick();
        set_core(0, MEM_EN_LD, 12'h3FF, 8'h00);
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (bif.core_ready != '0) begin
                lat = c; rdy = bif.core_ready; rd = bif.core_rdata;
                break;
            end
        end
        checks++; if (lat != 3) begin errors++; $display("[TB] FAIL load_after_store_latency: got %0d want 3", lat); end
        checks++; if (rdy !== 4'b0001) begin errors++; $display("[TB] FAIL load_after_store_ready: got %b want 0001", rdy); end
        checks++; if (rd !== 8'h5C) begin errors++; $display("[TB] FAIL load_after_store_rdata: got %h want 5c", rd); end
        set_core(0, MEM_EN_IDLE, 12'h000, 8'h00);
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_core(1, 2'b11, 12'h1AA, 8'h00);
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL illegal_busy_c%0d: got %0b want 0", c, busy); end
        end
        set_core(2, MEM_EN_LD, 12'h2AB, 8'h00);
        tick();
        checks++; if (bif.mem_addr !== 12'h2AB) begin errors++; $display("[TB] FAIL b2b_addr1: got %h want 2ab", bif.mem_addr); end
        checks++; if (gid !== 2'd2) begin errors++; $display("[TB] FAIL b2b_grant1: got %0d want 2", gid); end
        tick();
        tick();
        checks++; if (bif.core_ready !== 4'b0100) begin errors++; $display("[TB] FAIL b2b_ready1: got %b want 0100", bif.core_ready); end
        checks++; if (bif.core_rdata !== 8'h6D) begin errors++; $display("[TB] FAIL b2b_rdata1: got %h want 6d", bif.core_rdata); end
        tick();
        set_core(2, MEM_EN_LD, 12'h2AC, 8'h00);
        checks++; if (bif.core_ready !== 4'b0000) begin errors++; $display("[TB] FAIL b2b_no_dup_ready: got %b want 0000", bif.core_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle_between: got %0b want 0", busy); end
        tick();
        checks++; if (bif.mem_req !== 1'b1) begin errors++; $display("[TB] FAIL b2b_req2: got %0b want 1", bif.mem_req); end
        checks++; if (bif.mem_addr !== 12'h2AC) begin errors++; $display("[TB] FAIL b2b_addr2: got %h want 2ac", bif.mem_addr); end
        tick();
        checks++; if (bif.core_ready !== 4'b0000) begin errors++; $display("[TB] FAIL b2b_ready_wait: got %b want 0000", bif.core_ready); end
        tick();
        checks++; if (bif.core_ready !== 4'b0100) begin errors++; $display("[TB] FAIL b2b_ready2: got %b want 0100", bif.core_ready); end
        checks++; if (bif.core_rdata !== 8'h9E) begin errors++; $display("[TB] FAIL b2b_rdata2: got %h want 9e", bif.core_rdata); end
        bif.core_en = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_core(0, MEM_EN_LD, 12'h010, 8'h00);
        set_core(1, MEM_EN_LD, 12'h1AA, 8'h00);
        tick();
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL midreset_busy_wait: got %0b want 1", busy); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy: got %0b want 0", busy); end
        checks++; if (bif.core_ready !== 4'b0000) begin errors++; $display("[TB] FAIL midreset_ready: got %b want 0000", bif.core_ready); end
        checks++; if (bif.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL midreset_mem_req: got %0b want 0", bif.mem_req); end
        tick();
        checks++; if (bif.mem_req !== 1'b1) begin errors++; $display("[TB] FAIL midreset_reissue_req: got %0b want 1", bif.mem_req); end
        checks++; if (gid !== 2'd0) begin errors++; $display("[TB] FAIL midreset_rrptr_zero: grant %0d want 0", gid); end
        tick();
        tick();
        checks++; if (bif.core_ready !== 4'b0001) begin errors++; $display("[TB] FAIL midreset_ready_after: got %b want 0001", bif.core_ready); end
        checks++; if (bif.core_rdata !== 8'h11) begin errors++; $display("[TB] FAIL midreset_rdata: got %h want 11", bif.core_rdata); end
        bif.core_en = '0;
        tick();
    endtask

    task automatic test_lat1();
        bif1.core_en[5:4]        = MEM_EN_LD;
        bif1.core_addr[2*AW +: AW] = 12'h123;
        tick();
        checks++; if (bif1.mem_req !== 1'b1) begin errors++; $display("[TB] FAIL lat1_mem_req: got %0b want 1", bif1.mem_req); end
        checks++; if (bif1.mem_addr !== 12'h123) begin errors++; $display("[TB] FAIL lat1_mem_addr: got %h want 123", bif1.mem_addr); end
        checks++; if (gid1 !== 2'd2) begin errors++; $display("[TB] FAIL lat1_grant: got %0d want 2", gid1); end
        tick();
        checks++; if (bif1.core_ready !== 4'b0100) begin errors++; $display("[TB] FAIL lat1_ready_c2: got %b want 0100", bif1.core_ready); end
        checks++; if (bif1.core_rdata !== 8'hB4) begin errors++; $display("[TB] FAIL lat1_rdata: got %h want b4", bif1.core_rdata); end
        bif1.core_en = '0;
        tick();
        checks++; if (bif1.core_ready !== 4'b0000) begin errors++; $display("[TB] FAIL lat1_ready_c3: got %b want 0000", bif1.core_ready); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("[TB] FAIL lat1_busy_c3: got %0b want 0", busy1); end
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) begin
            mem0[a] = 8'h00;
            mem1[a] = 8'h00;
        end
        mem0[12'h105] = 8'hA7;
        mem0[12'h010] = 8'h11;
        mem0[12'h220] = 8'h22;
        mem0[12'h330] = 8'h33;
        mem0[12'h011] = 8'h44;
        mem0[12'h2AB] = 8'h6D;
        mem0[12'h2AC] = 8'h9E;
        mem1[12'h123] = 8'hB4;

        test_reset();
        test_single_load();
        test_contention();
        test_store_load();
        test_back_to_back();
        test_reset_mid();
        test_lat1();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached before summary");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
